// File: rtl/bus_sched.sv
// Three-master round-robin bus scheduler with beat-limited tenures.
// Each tenure is followed by one GAP cycle and one IDLE cycle.
module bus_sched #(
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       s_ready,
    output logic       m0_grant,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       busy,
    output logic [1:0] owner,
    output logic [3:0] beat_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_t;

    localparam logic [3:0] CntLast = 4'(MAX_BEATS - 1);
    localparam logic [1:0] NoOwner = 2'd3;

    state_t     state;
    logic [1:0] last_owner;
    logic [2:0] req;
    logic [1:0] winner;
    logic       owner_req;
    logic       release_now;

    assign req = {m2_req, m1_req, m0_req};

    // Round-robin search starts one past the previous owner.
    always_comb begin
        winner = 2'd0;
        case (last_owner)
            2'd0: begin
                if (req[1])      winner = 2'd1;
                else if (req[2]) winner = 2'd2;
                else             winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      winner = 2'd2;
                else if (req[0]) winner = 2'd0;
                else             winner = 2'd1;
            end
            default: begin
                if (req[0])      winner = 2'd0;
                else if (req[1]) winner = 2'd1;
                else             winner = 2'd2;
            end
        endcase
    end

    always_comb begin
        owner_req = 1'b0;
        case (owner)
            2'd0:    owner_req = req[0];
            2'd1:    owner_req = req[1];
            2'd2:    owner_req = req[2];
            default: owner_req = 1'b0;
        endcase
    end

    // A dropped request wins over a coincident beat: the beat is not counted.
    assign release_now = !owner_req || (s_ready && (beat_cnt == CntLast));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            last_owner <= 2'd2;
            m0_grant   <= 1'b0;
            m1_grant   <= 1'b0;
            m2_grant   <= 1'b0;
            busy       <= 1'b0;
            owner      <= NoOwner;
            beat_cnt   <= 4'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (|req) begin
                        state    <= StBusy;
                        owner    <= winner;
                        m0_grant <= (winner == 2'd0);
                        m1_grant <= (winner == 2'd1);
                        m2_grant <= (winner == 2'd2);
                        busy     <= 1'b1;
                        beat_cnt <= 4'd0;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        state      <= StGap;
                        last_owner <= owner;
                        owner      <= NoOwner;
                        m0_grant   <= 1'b0;
                        m1_grant   <= 1'b0;
                        m2_grant   <= 1'b0;
                        busy       <= 1'b0;
                        beat_cnt   <= 4'd0;
                    end else if (s_ready) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sched.sv
// Directed bench for bus_sched: a tenure-level reference model checked every
// cycle, plus hand-computed expectations at key points.
module tb_bus_sched;

    localparam int unsigned MaxBeats = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       m0_req = 1'b0;
    logic       m1_req = 1'b0;
    logic       m2_req = 1'b0;
    logic       s_ready = 1'b0;
    logic       m0_grant;
    logic       m1_grant;
    logic       m2_grant;
    logic       busy;
    logic [1:0] owner;
    logic [3:0] beat_cnt;

    always #5 clk = ~clk;

    bus_sched #(.MAX_BEATS(MaxBeats)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m2_req   (m2_req),
        .s_ready  (s_ready),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .m2_grant (m2_grant),
        .busy     (busy),
        .owner    (owner),
        .beat_cnt (beat_cnt)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    endtask

    // Reference model: owner 3 means no tenure; cool counts edges still to pass
    // after a release before requests are looked at again.
    logic [2:0] reqs;
    int m_owner = 3;
    int m_beats = 0;
    int m_last  = 2;
    int m_cool  = 0;
    int m_pick;

    assign reqs = {m2_req, m1_req, m0_req};

    always_comb begin
        m_pick = 3;
        for (int k = 3; k >= 1; k--) begin
            if (reqs[(m_last + k) % 3]) m_pick = (m_last + k) % 3;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner <= 3;
            m_beats <= 0;
            m_last  <= 2;
            m_cool  <= 0;
        end else if (m_owner != 3) begin
            if (!reqs[m_owner] || (s_ready && (m_beats + 1 == int'(MaxBeats)))) begin
                m_last  <= m_owner;
                m_owner <= 3;
                m_beats <= 0;
                m_cool  <= 1;
            end else if (s_ready) begin
                m_beats <= m_beats + 1;
            end
        end else if (m_cool > 0) begin
            m_cool <= m_cool - 1;
        end else if (m_pick != 3) begin
            m_owner <= m_pick;
            m_beats <= 0;
        end
    end

    logic [9:0] exp_vec;
    logic [9:0] act_vec;
    assign exp_vec = {m_owner == 0, m_owner == 1, m_owner == 2, m_owner != 3,
                      2'(m_owner), 4'(m_beats)};
    assign act_vec = {m0_grant, m1_grant, m2_grant, busy, owner, beat_cnt};

    always @(negedge clk) begin
        if (chk_en) check("outputs_vs_model", int'(act_vec), int'(exp_vec));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int rr_exp[4] = '{0, 1, 2, 0};
    int cnt;

    initial begin
        #2 reset_n = 1'b0;
        #1 chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_grants", int'({m0_grant, m1_grant, m2_grant}), 0);
        check("reset_owner", int'(owner), 3);
        check("reset_busy", int'(busy), 0);
        check("reset_beat_cnt", int'(beat_cnt), 0);
        @(negedge clk);
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m2_req  = 1'b1;
        s_ready = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        check("first_grant_m0", int'(m0_grant), 1);
        check("first_owner", int'(owner), 0);

        // Round robin with full-length tenures
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            while (busy && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            check("tenure_len", cnt, 8);
            cnt = 0;
            while (!busy && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            check("gap_idle_len", cnt, 2);
            check("rr_owner", int'(owner), rr_exp[i + 1]);
        end

        // Early release by m1 after three beats
        m0_req  = 1'b0;
        m2_req  = 1'b0;
        s_ready = 1'b0;
        cnt = 0;
        while (!m1_grant && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("m1_granted", int'(m1_grant), 1);
        s_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("early_beat_cnt", int'(beat_cnt), 3);
        m1_req  = 1'b0;
        s_ready = 1'b0;
        @(negedge clk);
        check("early_m1_drop", int'(m1_grant), 0);
        check("early_m0_low", int'(m0_grant), 0);
        check("early_owner", int'(owner), 3);

        // m2 tenure to beat 5, then asynchronous reset
        m2_req = 1'b1;
        cnt = 0;
        while (!m2_grant && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("m2_granted", int'(m2_grant), 1);
        s_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("m2_beat_cnt", int'(beat_cnt), 5);
        reset_n = 1'b0;
        #1;
        check("async_grants", int'({m0_grant, m1_grant, m2_grant}), 0);
        check("async_owner", int'(owner), 3);
        check("async_beat_cnt", int'(beat_cnt), 0);
        check("async_busy", int'(busy), 0);
        m0_req  = 1'b1;
        s_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_m0", int'(m0_grant), 1);
        check("post_reset_owner", int'(owner), 0);

        // Owner drops request on a beat edge: release, beat not counted
        s_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_drop_cnt", int'(beat_cnt), 2);
        m0_req = 1'b0;
        m2_req = 1'b0;
        @(negedge clk);
        check("drop_beat_m0", int'(m0_grant), 0);
        check("drop_beat_cnt", int'(beat_cnt), 0);
        check("drop_beat_owner", int'(owner), 3);

        // Idle stall, then a lone m2 request
        s_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_busy", int'(busy), 0);
            check("stall_owner", int'(owner), 3);
        end
        m2_req = 1'b1;
        @(negedge clk);
        check("stall_m2_grant", int'(m2_grant), 1);
        check("stall_m2_owner", int'(owner), 2);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
